// File: rtl/vga_fetch_fifo_if.sv
// Memory-side bus of the VGA prefetch unit: one outstanding read request,
// address held until granted, read data returned one cycle after acceptance.
interface vga_fetch_fifo_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic [15:0] mem_rdata;

  // Requester side (the prefetch unit)
  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rdata
  );

  // Arbiter / memory side
  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rdata
  );
endinterface

// File: rtl/vga_fetch_fifo.sv
// VGA prefetch unit: streams frame-buffer words from the shared memory port
// into a small show-ahead FIFO, so memory latency and arbitration stalls are
// absorbed before they reach the pixel path.
module vga_fetch_fifo #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          FRAME_WORDS = 38400,
  parameter int          DEPTH       = 16
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         frame_start,
  input  logic                         rd_en,
  output logic [15:0]                  glyph,
  output logic                         glyph_valid,
  output logic                         underflow,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  vga_fetch_fifo_if.master             mem
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_WORDS);
  localparam logic [LVL_W:0]   DEPTH_CMP = (LVL_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t           state, state_nxt;
  logic             req;
  logic             accept;
  logic             space_ok;
  logic             push;
  logic             pop;
  logic             vld_p1;      // a non-discarded read returns this cycle
  logic [15:0]      addr;
  logic [CNT_W-1:0] fetched;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [15:0]      fifo_mem [DEPTH];

  assign accept   = req & mem.mem_gnt;
  // The in-flight word already owns a slot, so a push can never find the FIFO full.
  assign space_ok = ({1'b0, level} + (LVL_W + 1)'(vld_p1)) < DEPTH_CMP;
  // frame_start flushes; a word landing in that cycle is simply dropped.
  assign push     = vld_p1 & ~frame_start;
  assign pop      = rd_en & glyph_valid & ~frame_start;

  assign glyph_valid  = (level != '0);
  assign glyph        = glyph_valid ? fifo_mem[rd_ptr] : 16'h0000;
  assign mem.mem_req  = req;
  assign mem.mem_addr = addr;

  // Fetch FSM: next state and request, throttled by FIFO space
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) state_nxt = FETCH;
      end
      FETCH: begin
        req = space_ok;
        if (frame_start) begin
          state_nxt = FETCH;
        end else if (accept && ((fetched + CNT_W'(1)) == LAST_CNT)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (frame_start) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch FSM state register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  // Address generator, frame word counter and return-stage flag
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      addr    <= BASE_ADDR;
      fetched <= '0;
      vld_p1  <= 1'b0;
    end else if (frame_start) begin
      addr    <= BASE_ADDR;
      fetched <= '0;
      vld_p1  <= 1'b0;   // a request accepted now returns after the flush: discard it
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        addr    <= addr + 16'd1;
        fetched <= fetched + CNT_W'(1);
      end
    end
  end

  // FIFO pointers, occupancy and sticky underflow
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (rd_en && !glyph_valid) underflow <= 1'b1;
    end
  end

  // FIFO storage: returned read data lands at the tail
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem.mem_rdata;
  end

endmodule

// File: tb/tb_vga_fetch_fifo.sv
// Bench for vga_fetch_fifo: randomized memory grants and VGA pops, with a
// queue-based model of the frame stream and a negedge scoreboard monitor.
module tb_vga_fetch_fifo;
  localparam logic [15:0] BASE  = 16'hFFF8;   // frame crosses the 16-bit address wrap
  localparam int          FW    = 40;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        clear;
  logic        frame_start;
  logic        rd_en;
  logic [15:0] glyph;
  logic        glyph_valid;
  logic        underflow;
  logic [4:0]  level;

  vga_fetch_fifo_if bus ();

  vga_fetch_fifo #(
    .BASE_ADDR   (BASE),
    .FRAME_WORDS (FW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .frame_start (frame_start),
    .rd_en       (rd_en),
    .glyph       (glyph),
    .glyph_valid (glyph_valid),
    .underflow   (underflow),
    .level       (level),
    .mem         (bus)
  );

  always #5 clk = ~clk;

  // Frame-buffer contents as a function of word address
  function automatic logic [15:0] pat(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  // Memory: returns the addressed word exactly one cycle after acceptance, junk otherwise
  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_gnt) bus.mem_rdata <= pat(bus.mem_addr);
    else                            bus.mem_rdata <= 16'($urandom);
  end

  // Reference model state
  logic [15:0] exp_q [$];
  int          acc_cnt;
  int          pop_idx;
  bit          fetching;
  bit          pend;
  logic [15:0] pend_word;
  bit          uf;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against model, then advance model through the coming edge
  int  exp_size;
  bit  accepted;
  always @(negedge clk) begin
    if (!clear) begin
      exp_q.delete();
      acc_cnt  = 0;
      pop_idx  = 0;
      fetching = 0;
      pend     = 0;
      uf       = 0;
    end
    exp_size = exp_q.size();
    check("level", 32'(level), 32'(exp_size));
    check("glyph_valid", 32'(glyph_valid), 32'(exp_size > 0));
    check("glyph", 32'(glyph), (exp_size > 0) ? 32'(exp_q[0]) : 32'h0);
    check("underflow", 32'(underflow), 32'(uf));
    check("mem_req", 32'(bus.mem_req), 32'(fetching && ((exp_size + int'(pend)) < DEPTH)));
    check("mem_addr", 32'(bus.mem_addr), 32'(16'(BASE + 16'(acc_cnt))));
    if (clear) begin
      accepted = bus.mem_req && bus.mem_gnt;
      if (frame_start) begin
        exp_q.delete();
        pend     = 0;
        acc_cnt  = 0;
        pop_idx  = 0;
        uf       = 0;
        fetching = 1;
      end else begin
        if (rd_en) begin
          if (exp_size > 0) begin
            check("pop_word", 32'(glyph), 32'(pat(16'(BASE + 16'(pop_idx)))));
            void'(exp_q.pop_front());
            pop_idx++;
          end else begin
            uf = 1;
          end
        end
        if (pend) exp_q.push_back(pend_word);
        if (accepted) begin
          pend      = 1;
          pend_word = pat(bus.mem_addr);
          acc_cnt++;
          if (acc_cnt == FW) fetching = 0;
        end else begin
          pend = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus
  initial begin
    int guard;
    clear       = 1'b0;
    frame_start = 1'b0;
    rd_en       = 1'b0;
    bus.mem_gnt = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    tick();

    // Fill the FIFO with grant held high and no pops
    bus.mem_gnt = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (24) tick();

    // Single pop from a full FIFO
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    repeat (6) tick();

    // Free space while the arbiter withholds grant, then release it
    bus.mem_gnt = 1'b0;
    rd_en = 1'b1;
    repeat (3) tick();
    rd_en = 1'b0;
    repeat (5) tick();
    bus.mem_gnt = 1'b1;
    repeat (6) tick();

    // frame_start while requests are being accepted and rd_en is high
    rd_en = 1'b1;
    repeat (3) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    rd_en = 1'b0;
    repeat (20) tick();

    // Underflow on an empty FIFO, then cleared by the next frame_start
    bus.mem_gnt = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    repeat (4) tick();

    // Whole frame with one pop every other cycle
    bus.mem_gnt = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    guard = 0;
    while (pop_idx < FW && guard < 600) begin
      rd_en = guard[0];
      tick();
      guard++;
    end
    rd_en = 1'b0;
    checks++;
    if (pop_idx < FW) begin
      errors++;
      $display("FAIL frame_drain: got %0d pops expected %0d", pop_idx, FW);
    end
    repeat (3) tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    repeat (4) tick();

    // Random traffic with occasional frame restarts and one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      bus.mem_gnt = ($urandom_range(0, 3) != 0);
      rd_en       = ($urandom_range(0, 2) != 0);
      frame_start = ($urandom_range(0, 149) == 0);
      clear       = !(i >= 1500 && i < 1502);
      tick();
    end
    frame_start = 1'b0;
    rd_en       = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
